// File: rtl/encoder104_keyscan.sv
// encoder104_keyscan: keypad front end that synchronises and debounces 10 one-hot key
// lines and emits the 4-bit index of the pressed key over a valid/ready handshake.
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   en     in   1   enable; low forces idle and clears outputs on the next edge
//   in     in  10   one-hot key lines, asynchronous to clk
//   ready  in   1   consumer takes out when valid && ready
//   out    out  4   index of the pressed key (0..9)
//   valid  out  1   out holds a code not yet accepted
//   err    out  1   one-cycle pulse when a debounced press had more than one key down
// Optional auto-repeat of a held key is built when ENC_REPEAT_EN is defined.
module encoder104_keyscan #(
   parameter int DEB_CYCLES    = 4,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [9:0] in,
   input  logic       ready,
   output logic [3:0] out,
   output logic       valid,
   output logic       err
);
   localparam int MAXC = (DEB_CYCLES > REPEAT_CYCLES) ? DEB_CYCLES : REPEAT_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
`ifdef ENC_REPEAT_EN
   // the cycle of the accepting handshake counts toward the repeat interval
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 2);
   logic [CW-1:0] rep;
`endif
   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESENT, RELEASE} state_t;
   state_t state;
   logic [9:0] sync1, s_in, sample;
   logic [CW-1:0] cnt;
   logic [3:0] idx;
   logic one_hot;
   always_comb begin
      idx = '0;
      for (int k = 0; k < 10; k++) if (sample[k]) idx = idx | 4'(k);
   end
   // clearing the lowest set bit leaves zero only for a single-bit value
   assign one_hot = (sample != '0) && ((sample & (sample - 10'd1)) == '0);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         s_in   <= '0;
         sample <= '0;
         cnt    <= '0;
         state  <= IDLE;
         out    <= '0;
         valid  <= 1'b0;
         err    <= 1'b0;
`ifdef ENC_REPEAT_EN
         rep    <= '0;
`endif
      end else begin
         sync1 <= in;
         s_in  <= sync1;
         err   <= 1'b0;
         if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= '0;
            valid <= 1'b0;
`ifdef ENC_REPEAT_EN
            rep   <= '0;
`endif
         end else begin
            case (state)
               IDLE: if (s_in != '0) begin
                  sample <= s_in;
                  cnt    <= '0;
                  state  <= DEBOUNCE;
               end
               DEBOUNCE: if (s_in != sample) begin
                  // bounce restarts the count on the new pattern, or gives up if released
                  cnt <= '0;
                  if (s_in == '0) state <= IDLE;
                  else sample <= s_in;
               end else if (cnt != DEB_LAST) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  cnt <= '0;
                  if (one_hot) begin
                     out   <= idx;
                     valid <= 1'b1;
                     state <= PRESENT;
                  end else begin
                     err   <= 1'b1;
                     state <= RELEASE;
                  end
               end
               PRESENT: if (ready) begin
                  valid <= 1'b0;
                  cnt   <= '0;
                  state <= RELEASE;
`ifdef ENC_REPEAT_EN
                  rep   <= '0;
`endif
               end
               RELEASE: begin
                  if (s_in != '0) cnt <= '0;
                  else if (cnt != DEB_LAST) cnt <= cnt + CW'(1);
                  else state <= IDLE;
`ifdef ENC_REPEAT_EN
                  // a multi-hot sample is never one-hot, so err presses cannot repeat
                  if (one_hot && s_in == sample) begin
                     if (rep == REP_LAST) begin
                        rep   <= '0;
                        valid <= 1'b1;
                        state <= PRESENT;
                     end else begin
                        rep <= rep + CW'(1);
                     end
                  end else begin
                     rep <= '0;
                  end
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_encoder104_keyscan.sv
// tb_encoder104_keyscan: directed bench for encoder104_keyscan with a code scoreboard.
module tb_encoder104_keyscan;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [9:0] in = '0;
   logic       ready = 1'b0;
   logic [3:0] out;
   logic       valid;
   logic       err;
   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int ecount = 0;
   logic [3:0] q[$];

   encoder104_keyscan #(.DEB_CYCLES(4), .REPEAT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in), .ready(ready),
      .out(out), .valid(valid), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // scoreboard: every accepted code must match the oldest expected press
   always @(negedge clk) begin
      if (rst_n && err) ecount++;
      if (rst_n && valid && ready) begin
         vcount++;
         chk("sb_pending", (q.size() != 0), 1);
         if (q.size() != 0) chk("sb_code", out, q.pop_front());
      end
   end

   initial begin
      tick(3);
      chk("rst_out", out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      en = 1'b1;
      ready = 1'b1;
      tick(2);
      // 1: single press, latency and single pulse
      in = 10'b00000_01000;
      q.push_back(4'd3);
      tick(6);
      chk("t1_valid_e6", valid, 0);
      tick(1);
      chk("t1_valid_e7", valid, 1);
      chk("t1_out_e7", out, 3);
      tick(1);
      chk("t1_valid_e8", valid, 0);
      tick(22);
      chk("t1_pulses", vcount, 1);
      in = '0;
      tick(12);
      // 2: sweep every key
      for (int k = 0; k < 10; k++) begin
         in = 10'(1) << k;
         q.push_back(4'(k));
         tick(12);
         in = '0;
         tick(12);
      end
      chk("t2_pulses", vcount, 11);
      chk("t2_q_empty", q.size(), 0);
      // 3: short glitch is rejected and FSM returns to IDLE
      in = 10'b00001_00000;
      tick(3);
      in = '0;
      tick(15);
      chk("t3_no_valid", vcount, 11);
      chk("t3_no_err", ecount, 0);
      in = 10'b00000_00010;
      q.push_back(4'd1);
      tick(6);
      chk("t3_idle_e6", valid, 0);
      tick(1);
      chk("t3_idle_e7", valid, 1);
      chk("t3_idle_out", out, 1);
      tick(5);
      in = '0;
      tick(12);
      // 4: multi-hot flagged as err, no code
      in = 10'b00000_10010;
      tick(6);
      chk("t4_err_e6", err, 0);
      tick(1);
      chk("t4_err_e7", err, 1);
      chk("t4_valid_e7", valid, 0);
      tick(1);
      chk("t4_err_e8", err, 0);
      tick(12);
      in = '0;
      tick(12);
      chk("t4_err_count", ecount, 1);
      chk("t4_no_valid", vcount, 12);
      // 5: backpressure holds code; new key ignored while pending
      ready = 1'b0;
      in = 10'b00100_00000;
      q.push_back(4'd7);
      tick(7);
      chk("t5_valid", valid, 1);
      chk("t5_out", out, 7);
      tick(3);
      in = 10'b00000_00100;
      tick(8);
      chk("t5_hold_valid", valid, 1);
      chk("t5_hold_out", out, 7);
      ready = 1'b1;
      tick(1);
      chk("t5_drop", valid, 0);
      chk("t5_keep_out", out, 7);
      in = '0;
      tick(12);
      in = 10'b00000_00100;
      q.push_back(4'd2);
      tick(12);
      in = '0;
      tick(12);
      chk("t5_out2", out, 2);
      // 6: enable drop while presenting, then async reset mid-debounce
      ready = 1'b0;
      in = 10'b00010_00000;
      tick(7);
      chk("t6_valid", valid, 1);
      chk("t6_out", out, 6);
      en = 1'b0;
      in = '0;
      tick(1);
      chk("t6_en_valid", valid, 0);
      chk("t6_en_out", out, 0);
      en = 1'b1;
      ready = 1'b1;
      tick(10);
      chk("t6_no_stale", vcount, 14);
      in = 10'b10000_00000;
      q.push_back(4'd9);
      tick(12);
      in = '0;
      tick(12);
      in = 10'b01000_00000;
      tick(4);
      chk("t6_pre_rst_out", out, 9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out", out, 0);
      chk("t6_rst_valid", valid, 0);
      chk("t6_rst_err", err, 0);
      in = '0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      in = 10'b00000_10000;
      q.push_back(4'd4);
      tick(6);
      chk("t6_post_e6", valid, 0);
      tick(1);
      chk("t6_post_e7", valid, 1);
      chk("t6_post_out", out, 4);
      tick(1);
      in = '0;
      tick(12);
      chk("final_pulses", vcount, 16);
      chk("final_q_empty", q.size(), 0);
      chk("final_err_count", ecount, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
